// File: rtl/image_buffer_rd_arbiter.sv
// Round-robin read arbiter for the frame image buffer: two fetchers share
// one read port, one read in flight, one-entry tagged response register.
module image_buffer_rd_arbiter #(
  parameter int PIXEL_SIZE     = 8,
  parameter int BUF_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0_valid,
  input  logic [BUF_ADDR_WIDTH-1:0] req0_addr,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [BUF_ADDR_WIDTH-1:0] req1_addr,
  output logic                      req1_ready,
  output logic                      rsp_valid,
  output logic                      rsp_id,
  output logic [PIXEL_SIZE-1:0]     rsp_data,
  input  logic                      rsp_ready,
  output logic [BUF_ADDR_WIDTH-1:0] buf_raddr,
  output logic                      buf_rvalid,
  input  logic                      buf_rready,
  input  logic [PIXEL_SIZE-1:0]     buf_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0] state;
  logic       rr_ptr;
  logic       id_q;
  logic       grant;
  logic       can_issue;
  logic       accept;

  always_comb begin
    grant = rr_ptr;
    if (req0_valid && !req1_valid)
      grant = 1'b0;
    else if (req1_valid && !req0_valid)
      grant = 1'b1;
  end

  // A free response slot includes one being drained this cycle.
  assign can_issue = (state == IDLE) && buf_rready &&
                     (!rsp_valid || rsp_ready);
  assign req0_ready = can_issue && req0_valid && !grant;
  assign req1_ready = can_issue && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      id_q       <= 1'b0;
      buf_raddr  <= '0;
      buf_rvalid <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      if (rsp_valid && rsp_ready)
        rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            buf_raddr  <= grant ? req1_addr : req0_addr;
            buf_rvalid <= 1'b1;
            id_q       <= grant;
            rr_ptr     <= ~grant;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          buf_rvalid <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          rsp_data  <= buf_rdata;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          buf_rvalid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_buffer_rd_arbiter.sv
// Directed bench for image_buffer_rd_arbiter with a behavioural
// buffer read-port model and hand-computed expectations.
module tb_image_buffer_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [15:0] req0_addr = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_addr = '0;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_ready = 1'b1;
  logic [15:0] buf_raddr;
  logic        buf_rvalid;
  logic        buf_rready;
  logic [7:0]  buf_rdata;

  logic [7:0]  mem [0:15];
  logic        bm_rdy = 1'b1;
  logic [7:0]  bm_rdata = '0;
  logic        stall = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign buf_rready = bm_rdy && !stall;
  assign buf_rdata  = bm_rdata;

  always @(posedge clk) begin
    if (buf_rvalid && buf_rready) begin
      bm_rdata <= mem[buf_raddr[3:0]];
      bm_rdy   <= 1'b0;
    end else begin
      bm_rdy <= 1'b1;
    end
  end

  image_buffer_rd_arbiter #(
    .PIXEL_SIZE(8),
    .BUF_ADDR_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req0_valid(req0_valid),
    .req0_addr(req0_addr),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr(req1_addr),
    .req1_ready(req1_ready),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_ready(rsp_ready),
    .buf_raddr(buf_raddr),
    .buf_rvalid(buf_rvalid),
    .buf_rready(buf_rready),
    .buf_rdata(buf_rdata)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    stall      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic e0, e1, eid;
    logic [7:0] ed;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[1] = 8'h11;
    mem[2] = 8'h22;
    mem[5] = 8'h3C;
    mem[7] = 8'h77;
    mem[9] = 8'h99;

    req0_valid = 1'b0;
    tick();
    #1;
    chk("rst_rvalid", buf_rvalid, 1'b0);
    chk("rst_raddr", buf_raddr, 16'h0000);
    chk("rst_rspv", rsp_valid, 1'b0);
    chk("rst_rspid", rsp_id, 1'b0);
    chk("rst_rspd", rsp_data, 8'h00);
    chk("rst_rdy0", req0_ready, 1'b0);
    chk("rst_rdy1", req1_ready, 1'b0);

    do_reset();
    tick();
    req0_valid = 1'b1;
    req0_addr  = 16'd5;
    #1;
    chk("s_rdy0", req0_ready, 1'b1);
    chk("s_rdy1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("s_rv1", buf_rvalid, 1'b1);
    chk("s_ra1", buf_raddr, 16'd5);
    chk("s_rdy0_busy", req0_ready, 1'b0);
    tick();
    #1;
    chk("s_rv2", buf_rvalid, 1'b0);
    chk("s_rspv2", rsp_valid, 1'b0);
    tick();
    #1;
    chk("s_rspv3", rsp_valid, 1'b1);
    chk("s_rspid3", rsp_id, 1'b0);
    chk("s_rspd3", rsp_data, 8'h3C);
    tick();
    #1;
    chk("s_rspv4", rsp_valid, 1'b0);

    do_reset();
    for (int c = 0; c <= 12; c++) begin
      tick();
      req0_valid = 1'b1;
      req0_addr  = 16'd1;
      req1_valid = 1'b1;
      req1_addr  = 16'd2;
      #1;
      e0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
      e1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
      if (c <= 9) begin
        chk("c_rdy0", req0_ready, e0);
        chk("c_rdy1", req1_ready, e1);
      end
      if (c >= 3 && c % 3 == 0) begin
        eid = (((c / 3) - 1) % 2) == 1;
        ed  = eid ? 8'h22 : 8'h11;
        chk("c_rspv", rsp_valid, 1'b1);
        chk("c_rspid", rsp_id, eid);
        chk("c_rspd", rsp_data, ed);
      end else begin
        chk("c_rspv0", rsp_valid, 1'b0);
      end
    end

    do_reset();
    tick();
    req0_valid = 1'b1;
    req0_addr  = 16'd1;
    req1_valid = 1'b1;
    req1_addr  = 16'd2;
    #1;
    chk("b_rdy0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();
    for (int c = 3; c <= 7; c++) begin
      tick();
      rsp_ready = 1'b0;
      #1;
      chk("b_rspv", rsp_valid, 1'b1);
      chk("b_rspid", rsp_id, 1'b0);
      chk("b_rspd", rsp_data, 8'h11);
      chk("b_rdy1", req1_ready, 1'b0);
    end
    tick();
    rsp_ready = 1'b1;
    #1;
    chk("b_rspd8", rsp_data, 8'h11);
    chk("b_rdy1_8", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("b_rv9", buf_rvalid, 1'b1);
    chk("b_ra9", buf_raddr, 16'd2);
    chk("b_rspv9", rsp_valid, 1'b0);
    tick();
    tick();
    #1;
    chk("b_rspv11", rsp_valid, 1'b1);
    chk("b_rspid11", rsp_id, 1'b1);
    chk("b_rspd11", rsp_data, 8'h22);

    do_reset();
    for (int c = 0; c <= 4; c++) begin
      tick();
      stall      = 1'b1;
      req0_valid = 1'b1;
      req0_addr  = 16'd9;
      #1;
      chk("k_rdy0", req0_ready, 1'b0);
      chk("k_rv", buf_rvalid, 1'b0);
    end
    tick();
    stall = 1'b0;
    #1;
    chk("k_rdy0_5", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("k_rv6", buf_rvalid, 1'b1);
    tick();
    tick();
    #1;
    chk("k_rspv8", rsp_valid, 1'b1);
    chk("k_rspd8", rsp_data, 8'h99);

    do_reset();
    tick();
    req0_valid = 1'b1;
    req0_addr  = 16'd5;
    tick();
    req0_valid = 1'b0;
    #1;
    chk("m_rv1", buf_rvalid, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("m_rv_rst", buf_rvalid, 1'b0);
    chk("m_rspv_rst", rsp_valid, 1'b0);
    tick();
    rst_n      = 1'b1;
    req0_valid = 1'b1;
    req0_addr  = 16'd7;
    #1;
    chk("m_rdy0", req0_ready, 1'b1);
    for (int c = 4; c <= 5; c++) begin
      tick();
      req0_valid = 1'b0;
      #1;
      chk("m_rspv_stale", rsp_valid, 1'b0);
    end
    tick();
    #1;
    chk("m_rspv6", rsp_valid, 1'b1);
    chk("m_rspid6", rsp_id, 1'b0);
    chk("m_rspd6", rsp_data, 8'h77);

    do_reset();
    tick();
    req0_valid = 1'b1;
    req0_addr  = 16'd1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      #1;
      chk("i_rv", buf_rvalid, 1'b0);
      chk("i_rspv", rsp_valid, 1'b0);
    end
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req1_addr  = 16'd2;
    #1;
    chk("i_rdy0", req0_ready, 1'b0);
    chk("i_rdy1", req1_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
